// File: rtl/sopc_be_mem_pkg.sv
// sopc_be_mem_pkg: shared constants and master ids for the on-chip memory arbiter.
// No ports; imported by the arbiter core and the top level.
package sopc_be_mem_pkg;
   localparam int MEM_ADDR_W = 9;
   localparam int MEM_DATA_W = 1024;
   localparam int MEM_DEPTH  = 313;
   localparam int MEM_BE_W   = MEM_DATA_W / 8;
   typedef enum logic {M0 = 1'b0, M1 = 1'b1} master_id_t;
endpackage

// File: rtl/sopc_be_rr_arbiter_2.sv
// sopc_be_rr_arbiter_2: two-way round-robin grant with a bounded hold.
// Ports: clk, reset (async, active high), req0/req1 requests in,
// grant0/grant1 one-hot grants out (combinational from the current requests).
module sopc_be_rr_arbiter_2
   import sopc_be_mem_pkg::*;
#(
   parameter int MAX_HOLD = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic req0,
   input  logic req1,
   output logic grant0,
   output logic grant1
);
   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] MAX_H = HW'(MAX_HOLD);
   master_id_t    last_grant, win;
   logic [HW-1:0] hold_cnt;
   logic          both, any, hold;
   // A zero hold count means no contended streak is running, so contention
   // starts by handing the grant to the master that was not served last.
   always_comb begin
      both   = req0 & req1;
      any    = req0 | req1;
      hold   = (hold_cnt != '0) && (hold_cnt < MAX_H);
      win    = both ? (hold ? last_grant : (last_grant == M0 ? M1 : M0))
                    : (req1 ? M1 : M0);
      grant0 = any & (win == M0);
      grant1 = any & (win == M1);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant <= M1;
         hold_cnt   <= '0;
      end else begin
         if (any) last_grant <= win;
         hold_cnt <= !both ? '0 : (win != last_grant ? HW'(1) : hold_cnt + HW'(1));
      end
   end
endmodule

// File: rtl/sopc_be_onchip_mem_arbiter.sv
// sopc_be_onchip_mem_arbiter: shares the single-port 313 x 1024-bit on-chip
// memory between a loader master (m0) and a compute/readback master (m1).
// Ports: clk, reset (async, active high); per master mX_address/read/write/
// byteenable/writedata in and mX_waitrequest/readdata/readdatavalid out;
// memory side mem_address/byteenable/chipselect/write/writedata/clken out and
// mem_readdata in (1-cycle latency); oor_count saturating out-of-range count.
module sopc_be_onchip_mem_arbiter
   import sopc_be_mem_pkg::*;
#(
   parameter int ADDR_W   = MEM_ADDR_W,
   parameter int DATA_W   = MEM_DATA_W,
   parameter int DEPTH    = MEM_DEPTH,
   parameter int MAX_HOLD = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   input  logic [DATA_W-1:0]   m0_writedata,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   input  logic [DATA_W-1:0]   m1_writedata,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                m1_readdatavalid,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_writedata,
   output logic                mem_clken,
   input  logic [DATA_W-1:0]   mem_readdata,
   output logic [15:0]         oor_count
);
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
   logic       req0, req1, gnt0, gnt1, acc, wr, in_range;
   logic       rd_pend, rd_oor;
   master_id_t sel, rd_owner;
   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;
   sopc_be_rr_arbiter_2 #(.MAX_HOLD(MAX_HOLD)) u_arb (
      .clk    (clk),
      .reset  (reset),
      .req0   (req0),
      .req1   (req1),
      .grant0 (gnt0),
      .grant1 (gnt1)
   );
   // Read+write together counts as a write; out-of-range accesses are
   // accepted but never reach the memory.
   always_comb begin
      sel            = gnt1 ? M1 : M0;
      acc            = ~reset & (gnt0 | gnt1);
      mem_address    = sel == M1 ? m1_address    : m0_address;
      mem_byteenable = sel == M1 ? m1_byteenable : m0_byteenable;
      mem_writedata  = sel == M1 ? m1_writedata  : m0_writedata;
      wr             = sel == M1 ? m1_write      : m0_write;
      in_range       = {1'b0, mem_address} < DEPTH_L;
      mem_chipselect = acc & in_range;
      mem_write      = mem_chipselect & wr;
      mem_clken      = 1'b1;
      m0_waitrequest = reset | (req0 & ~gnt0);
      m1_waitrequest = reset | (req1 & ~gnt1);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_pend   <= 1'b0;
         rd_owner  <= M0;
         rd_oor    <= 1'b0;
         oor_count <= '0;
      end else begin
         rd_pend  <= acc & ~wr;
         rd_owner <= sel;
         rd_oor   <= ~in_range;
         if (acc & ~in_range & (oor_count != 16'hFFFF)) oor_count <= oor_count + 16'd1;
      end
   end
   always_comb begin
      m0_readdatavalid = rd_pend & (rd_owner == M0);
      m1_readdatavalid = rd_pend & (rd_owner == M1);
      m0_readdata      = (m0_readdatavalid & ~rd_oor) ? mem_readdata : '0;
      m1_readdata      = (m1_readdatavalid & ~rd_oor) ? mem_readdata : '0;
   end
endmodule
